serial_addsub_ctrl: RTL



---
 rtl/serial_addsub_ctrl_pkg.sv | 15 +
 rtl/serial_addsub_ctrl_full_add.sv | 18 +
 rtl/serial_addsub_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/serial_addsub_ctrl_pkg.sv
// Shared definitions for the bit-serial adder/subtractor controller.
//   state_t : sequencer states (IDLE, RUN, DONE)
//   OP_ADD / OP_SUB : encoding of the 'sub' operation-select input
package serial_addsub_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_ctrl_full_add.sv
// One-bit full-adder cell shared by the serial arithmetic paths.
// Ports:
//   a, b  : input  operand bits
//   cin   : input  carry in
//   y     : output sum bit
//   carry : output carry out
module full_add (
    output logic y,
    output logic carry,
    input  logic cin,
    input  logic a,
    input  logic b
);

    assign y     = a ^ b ^ cin;
    assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial adder/subtractor sequencer. Captures two WIDTH-bit operands on
// start, feeds one full_add cell LSB first through a carry flip-flop and
// reports the result, carry-out and signed overflow with a one-cycle done.
// Ports:
//   clk      : input  system clock (rising edge)
//   rst      : input  asynchronous active-high reset
//   start    : input  request, accepted in IDLE or DONE
//   sub      : input  0 = a+b, 1 = a-b (sampled with start)
//   a, b     : input  WIDTH-bit operands (sampled with start)
//   busy     : output high while the operation runs
//   done     : output one-cycle completion pulse
//   result   : output WIDTH-bit sum/difference, held until next completion
//   cout     : output carry out of MSB (for sub: 1 = no borrow)
//   overflow : output two's-complement overflow
module serial_addsub_ctrl
    import serial_addsub_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-2:0] r_sum;     // upper sum bits collected so far
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_overflow;
    logic             r_busy;
    logic             r_done;

    logic             w_y;
    logic             w_carry;
    logic [WIDTH-1:0] w_sum_next;

    full_add u_cell (
        .y     (w_y),
        .carry (w_carry),
        .cin   (r_carry),
        .a     (r_a[0]),
        .b     (r_b[0])
    );

    // New sum bit enters at the MSB; after WIDTH shifts the LSB sits at bit 0.
    assign w_sum_next = {w_y, r_sum};

    // NOTE: every register here is written with <= so all state updates
    // observe the pre-edge values, exactly as the hardware flops do.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_sum      <= '0;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            r_result   <= '0;
            r_cout     <= 1'b0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        // Subtraction is a + ~b + 1: invert B and preset carry.
                        r_a     <= a;
                        r_b     <= (sub == OP_ADD) ? b : ~b;
                        r_carry <= (sub == OP_SUB);
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_sum   <= w_sum_next[WIDTH-1:1];
                    r_carry <= w_carry;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        // On the MSB step r_carry is the carry into the MSB,
                        // so overflow is that carry-in XOR the final carry.
                        r_result   <= w_sum_next;
                        r_cout     <= w_carry;
                        r_overflow <= r_carry ^ w_carry;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign result   = r_result;
    assign cout     = r_cout;
    assign overflow = r_overflow;

endmodule
